// File: rtl/cnn_frame_scheduler.sv
// Batch sequencer for the BNN CNN core: starts each image, streams NPIX
// pixel words on core strobes, waits for done and decodes the result.
module cnn_frame_scheduler #(
    parameter int PIX_W = 32,
    parameter int NPIX  = 784,
    parameter int NCLS  = 10,
    parameter int TMO   = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [15:0]      n_frames,
    input  logic             abort,
    input  logic             s_valid,
    input  logic [PIX_W-1:0] s_data,
    output logic             s_ready,
    output logic             cnn_start,
    output logic [PIX_W-1:0] cnn_din,
    input  logic             cnn_din_ready,
    input  logic [NCLS-1:0]  cnn_classes,
    input  logic             cnn_done,
    output logic             res_valid,
    output logic [3:0]       res_label,
    output logic [NCLS-1:0]  res_classes,
    output logic [3:0]       res_err,
    output logic [15:0]      res_frame,
    output logic             busy,
    output logic             batch_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_LOAD, S_WAIT, S_REPORT
    } state_t;

    localparam logic [10:0] LAST_PIX = 11'(NPIX - 1);
    localparam logic [15:0] TMO_C    = 16'(TMO);

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_nfr;
    logic [15:0]       r_frame;
    logic [15:0]       r_wd;
    logic [10:0]       r_pix;
    logic [3:0]        r_err;
    logic [3:0]        r_label;
    logic [3:0]        r_rerr;
    logic [NCLS-1:0]   r_rcls;
    logic [15:0]       r_rframe;

    logic              w_strobe;
    logic              w_under;
    logic              w_early;
    logic              w_tmo;
    logic              w_cap;
    logic              w_more;
    logic [NCLS-1:0]   w_cls;
    logic [3:0]        w_lab;
    logic [4:0]        w_pop;
    logic [3:0]        w_err_cap;

    assign w_strobe = (r_state == S_LOAD) && cnn_din_ready;
    assign w_under  = w_strobe && !s_valid;
    assign w_early  = (r_state == S_LOAD) && cnn_done;
    assign w_tmo    = (r_state == S_WAIT) && !cnn_done && (r_wd == TMO_C);
    assign w_cap    = w_early || ((r_state == S_WAIT) && (cnn_done || r_wd == TMO_C));
    assign w_more   = ({1'b0, r_frame} + 17'd1) < {1'b0, r_nfr};
    assign w_cls    = w_tmo ? '0 : cnn_classes;

    // Lowest set bit wins the label; an empty vector decodes to 0xF.
    always_comb begin
        w_lab = 4'hF;
        w_pop = 5'd0;
        for (int i = NCLS - 1; i >= 0; i--) begin
            if (w_cls[i]) begin
                w_lab = 4'(i);
            end
            w_pop = w_pop + {4'd0, w_cls[i]};
        end
    end

    assign w_err_cap = r_err | {w_early, (w_pop != 5'd1), w_tmo, w_under};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (go) w_next = S_START;
                S_START:  w_next = S_LOAD;
                S_LOAD: begin
                    if (cnn_done) begin
                        w_next = S_REPORT;
                    end else if (cnn_din_ready && r_pix == LAST_PIX) begin
                        w_next = S_WAIT;
                    end
                end
                S_WAIT:   if (w_cap) w_next = S_REPORT;
                S_REPORT: w_next = w_more ? S_START : S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Handshake outputs are masked by abort so nothing leaks in that cycle.
    always_comb begin
        busy       = (r_state != S_IDLE);
        cnn_start  = (r_state == S_START) && !abort;
        s_ready    = w_strobe && !abort;
        cnn_din    = ((r_state == S_LOAD) && s_valid) ? s_data : '0;
        res_valid  = (r_state == S_REPORT) && !abort;
        batch_done = res_valid && !w_more;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nfr    <= '0;
            r_frame  <= '0;
            r_wd     <= '0;
            r_pix    <= '0;
            r_err    <= '0;
            r_label  <= '0;
            r_rerr   <= '0;
            r_rcls   <= '0;
            r_rframe <= '0;
        end else if (!abort) begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_nfr   <= (n_frames == 16'd0) ? 16'd1 : n_frames;
                        r_frame <= '0;
                    end
                end
                S_START: begin
                    r_pix <= '0;
                    r_err <= '0;
                    r_wd  <= '0;
                end
                S_LOAD: begin
                    if (cnn_din_ready) r_pix <= r_pix + 11'd1;
                    if (w_under) r_err[0] <= 1'b1;
                end
                S_WAIT:   if (!w_cap) r_wd <= r_wd + 16'd1;
                S_REPORT: if (w_more) r_frame <= r_frame + 16'd1;
                default: ;
            endcase
            if (w_cap) begin
                r_rcls   <= w_cls;
                r_label  <= w_lab;
                r_rerr   <= w_err_cap;
                r_rframe <= r_frame;
            end
        end
    end

    assign res_label   = r_label;
    assign res_classes = r_rcls;
    assign res_err     = r_rerr;
    assign res_frame   = r_rframe;

endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// Directed bench for cnn_frame_scheduler: a core/host model drives frames,
// expected results go into a queue and a monitor checks each res_valid.
module tb_cnn_frame_scheduler;

    localparam int PIX_W = 32;
    localparam int NPIX  = 784;
    localparam int NCLS  = 10;
    localparam int TMO   = 1000;

    typedef struct packed {
        logic [3:0]  lab;
        logic [9:0]  cls;
        logic [3:0]  err;
        logic [15:0] frame;
        logic        last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             go;
    logic [15:0]      n_frames;
    logic             abort;
    logic             s_valid;
    logic [PIX_W-1:0] s_data;
    logic             s_ready;
    logic             cnn_start;
    logic [PIX_W-1:0] cnn_din;
    logic             cnn_din_ready;
    logic [NCLS-1:0]  cnn_classes;
    logic             cnn_done;
    logic             res_valid;
    logic [3:0]       res_label;
    logic [NCLS-1:0]  res_classes;
    logic [3:0]       res_err;
    logic [15:0]      res_frame;
    logic             busy;
    logic             batch_done;

    int          n_vec = 0;
    int          n_mis = 0;
    int          n_cons = 0;
    int          n_starts = 0;
    logic [31:0] hw = 32'hA500_0000;
    exp_t        q[$];

    cnn_frame_scheduler #(
        .PIX_W(PIX_W), .NPIX(NPIX), .NCLS(NCLS), .TMO(TMO)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .n_frames(n_frames),
        .abort(abort), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .cnn_start(cnn_start), .cnn_din(cnn_din),
        .cnn_din_ready(cnn_din_ready), .cnn_classes(cnn_classes),
        .cnn_done(cnn_done), .res_valid(res_valid), .res_label(res_label),
        .res_classes(res_classes), .res_err(res_err),
        .res_frame(res_frame), .busy(busy), .batch_done(batch_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: counts host words and start pulses, checks every result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (s_ready && s_valid) n_cons++;
            if (cnn_start) n_starts++;
            if (res_valid) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL unexpected_res: res_valid=1 required 0 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("res_label", 32'(res_label), 32'(e.lab));
                    chk("res_classes", 32'(res_classes), 32'(e.cls));
                    chk("res_err", 32'(res_err), 32'(e.err));
                    chk("res_frame", 32'(res_frame), 32'(e.frame));
                    chk("batch_done", 32'(batch_done), 32'(e.last));
                end
            end else if (batch_done) begin
                n_vec++;
                n_mis++;
                $display("FAIL stray_batch_done: batch_done=1 required 0 at %0t", $time);
            end
        end
    end

    task automatic push_exp(input logic [3:0] lab, input logic [9:0] cls,
                            input logic [3:0] err, input logic [15:0] frame,
                            input logic last);
        exp_t e;
        e.lab   = lab;
        e.cls   = cls;
        e.err   = err;
        e.frame = frame;
        e.last  = last;
        q.push_back(e);
    endtask

    task automatic go_batch(input logic [15:0] n);
        n_cons   = 0;
        n_starts = 0;
        n_frames = n;
        go       = 1'b1;
        tick();
        go = 1'b0;
        chk("go_busy", 32'(busy), 32'd1);
    endtask

    // One frame as seen by the core; entered in the START cycle.
    task automatic do_frame(input logic [9:0] cls, input int done_at,
                            input bit tmo, input int drop_lo, input int drop_hi,
                            input logic [3:0] lab, input logic [3:0] err,
                            input logic [15:0] frame, input logic last,
                            input int abort_at, input int rst_at,
                            input bit go_end);
        int k;
        chk("start", 32'(cnn_start), 32'd1);
        tick();
        for (int p = 0; p < NPIX; p++) begin
            s_valid       = !(p >= drop_lo && p <= drop_hi);
            s_data        = hw;
            cnn_din_ready = 1'b1;
            if (p == abort_at) abort = 1'b1;
            if (p == done_at) begin
                cnn_done    = 1'b1;
                cnn_classes = cls;
                push_exp(lab, cls, err, frame, last);
            end
            #1;
            if (p == abort_at) begin
                chk("abort_sready", 32'(s_ready), 32'd0);
                cnn_din_ready = 1'b0;
                s_valid       = 1'b0;
                tick();
                abort = 1'b0;
                chk("abort_busy", 32'(busy), 32'd0);
                return;
            end
            if (p == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_sready", 32'(s_ready), 32'd0);
                chk("rst_start", 32'(cnn_start), 32'd0);
                chk("rst_resv", 32'(res_valid), 32'd0);
                chk("rst_bdone", 32'(batch_done), 32'd0);
                chk("rst_din", cnn_din, 32'd0);
                chk("rst_label", 32'(res_label), 32'd0);
                chk("rst_cls", 32'(res_classes), 32'd0);
                chk("rst_err", 32'(res_err), 32'd0);
                chk("rst_frame", 32'(res_frame), 32'd0);
                #1;
                rst           = 1'b0;
                cnn_din_ready = 1'b0;
                s_valid       = 1'b0;
                tick();
                return;
            end
            chk("din", cnn_din, s_valid ? hw : 32'd0);
            chk("sready", 32'(s_ready), 32'd1);
            if (s_valid) hw++;
            tick();
            cnn_done = 1'b0;
            if (p == done_at) begin
                chk("early_resv", 32'(res_valid), 32'd1);
                chk("early_sready", 32'(s_ready), 32'd0);
                cnn_din_ready = 1'b0;
                s_valid       = 1'b0;
                tick();
                return;
            end
        end
        cnn_din_ready = 1'b0;
        s_valid       = 1'b0;
        if (tmo) begin
            push_exp(lab, 10'd0, err, frame, last);
            k = 0;
            for (int c = 1; c <= TMO + 50; c++) begin
                tick();
                k = c;
                if (res_valid) break;
            end
            chk("tmo_latency", 32'(k), 32'(TMO + 1));
            tick();
        end else begin
            repeat (3) tick();
            cnn_done    = 1'b1;
            cnn_classes = cls;
            push_exp(lab, cls, err, frame, last);
            tick();
            cnn_done = 1'b0;
            chk("res_latency", 32'(res_valid), 32'd1);
            if (go_end) go = 1'b1;
            tick();
            go = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        go            = 1'b0;
        n_frames      = 16'd0;
        abort         = 1'b0;
        s_valid       = 1'b0;
        s_data        = '0;
        cnn_din_ready = 1'b0;
        cnn_classes   = '0;
        cnn_done      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_start", 32'(cnn_start), 32'd0);
        chk("reset_resv", 32'(res_valid), 32'd0);
        chk("reset_label", 32'(res_label), 32'd0);
        chk("reset_err", 32'(res_err), 32'd0);
        rst = 1'b0;
        tick();

        // single frame, go during batch_done must be ignored
        go_batch(16'd1);
        do_frame(10'h008, -1, 0, -1, -1, 4'd3, 4'b0000, 16'd0, 1'b1, -1, -1, 1);
        chk("single_busy", 32'(busy), 32'd0);
        chk("single_start_after", 32'(cnn_start), 32'd0);
        chk("single_cons", 32'(n_cons), 32'd784);
        chk("single_starts", 32'(n_starts), 32'd1);

        go_batch(16'd3);
        do_frame(10'h001, -1, 0, -1, -1, 4'd0, 4'b0000, 16'd0, 1'b0, -1, -1, 0);
        do_frame(10'h200, -1, 0, -1, -1, 4'd9, 4'b0000, 16'd1, 1'b0, -1, -1, 0);
        do_frame(10'h040, -1, 0, -1, -1, 4'd6, 4'b0000, 16'd2, 1'b1, -1, -1, 0);
        chk("batch_busy", 32'(busy), 32'd0);
        chk("batch_cons", 32'(n_cons), 32'd2352);
        chk("batch_starts", 32'(n_starts), 32'd3);

        go_batch(16'd1);
        do_frame(10'h010, -1, 0, 100, 104, 4'd4, 4'b0001, 16'd0, 1'b1, -1, -1, 0);
        chk("drop_cons", 32'(n_cons), 32'd779);

        // n_frames=0 runs one frame; core stays silent
        go_batch(16'd0);
        do_frame(10'h000, -1, 1, -1, -1, 4'hF, 4'b0110, 16'd0, 1'b1, -1, -1, 0);
        chk("tmo_busy", 32'(busy), 32'd0);

        go_batch(16'd1);
        do_frame(10'h0C0, -1, 0, -1, -1, 4'd6, 4'b0100, 16'd0, 1'b1, -1, -1, 0);

        go_batch(16'd1);
        do_frame(10'h002, 500, 0, -1, -1, 4'd1, 4'b1000, 16'd0, 1'b1, -1, -1, 0);
        chk("early_busy", 32'(busy), 32'd0);

        go_batch(16'd3);
        do_frame(10'h004, -1, 0, -1, -1, 4'd2, 4'b0000, 16'd0, 1'b0, -1, -1, 0);
        do_frame(10'h000, -1, 0, -1, -1, 4'd0, 4'b0000, 16'd1, 1'b0, 400, -1, 0);
        repeat (5) tick();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_starts", 32'(n_starts), 32'd2);

        go_batch(16'd2);
        do_frame(10'h000, -1, 0, -1, -1, 4'd0, 4'b0000, 16'd0, 1'b0, -1, 300, 0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        go_batch(16'd1);
        do_frame(10'h100, -1, 0, -1, -1, 4'd8, 4'b0000, 16'd0, 1'b1, -1, -1, 0);
        repeat (3) tick();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/cnn_frame_scheduler.md
# cnn_frame_scheduler

Sequencer sitting between the host image stream and the `CNN` core of the BNN accelerator. It runs a batch of N images through the core: pulses `start`, streams exactly 784 pixel words on the core's `din_ready` strobes, waits for `done`, then captures and decodes `classes` into a label, an error code and a frame number. It replaces file-driven stimulus with a synthesizable front-end for on-board batch inference.

## Interface
- `PIX_W`, 32, pixel word width (matches core `din`)
- `NPIX`, 784, words per image
- `NCLS`, 10, width of core `classes`
- `TMO`, 65535, max cycles in WAIT before timeout (16-bit counter)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `go`  in  1  one-cycle request to start a batch; ignored unless IDLE
- `n_frames`  in  16  batch length, sampled on accepted `go`; 0 treated as 1
- `abort`  in  1  synchronous return to IDLE from any state
- `s_valid` / `s_data`  in  1 / PIX_W  host pixel stream
- `s_ready`  out  1  host word consumed this cycle
- `cnn_start`  out  1  one-cycle start pulse to core
- `cnn_din`  out  PIX_W  pixel to core
- `cnn_din_ready`  in  1  core samples `cnn_din` this cycle
- `cnn_classes`  in  NCLS  core result vector
- `cnn_done`  in  1  core result valid (one cycle)
- `res_valid`  out  1  one-cycle result strobe
- `res_label`  out  4  index of lowest set bit of captured classes
- `res_classes`  out  NCLS  captured classes
- `res_err`  out  4  [0] underrun, [1] timeout, [2] classes not one-hot, [3] early done
- `res_frame`  out  16  frame index within batch, 0-based
- `busy`  out  1  state != IDLE
- `batch_done`  out  1  one-cycle pulse after last result

## Operation
- States: IDLE, START, LOAD, WAIT, REPORT.
- IDLE: `go` -> latch `n_frames`, clear frame counter -> START.
- START: `cnn_start`=1 for this one cycle, clear pixel counter, error bits, watchdog -> LOAD.
- LOAD: `cnn_din` = `s_valid ? s_data : 0` (combinational); `s_ready` = `cnn_din_ready` (combinational, LOAD only). Each cycle with `cnn_din_ready`=1 increments pixel counter (11 bits); if `s_valid`=0 that cycle set err[0], zero word sent, no host word consumed. On the NPIX-th strobe -> WAIT. `cnn_done` in LOAD: set err[3], capture classes -> REPORT.
- WAIT: watchdog increments each cycle; `cnn_done` -> capture `cnn_classes` -> REPORT. Watchdog reaching TMO -> set err[1], capture zeros -> REPORT.
- REPORT: `res_valid`=1 one cycle; err[2] set when popcount(captured) != 1; `res_label` = lowest set bit index, 0xF when vector zero. If frame counter + 1 < batch length -> increment counter, START; else `batch_done`=1, IDLE.
- `abort` has priority over every transition: -> IDLE, no `res_valid`, no `batch_done`; host words not yet consumed stay with host.
- `cnn_din_ready` outside LOAD is ignored; `cnn_done` outside LOAD/WAIT is ignored.

## Timing
- Reset: state IDLE; `s_ready`, `cnn_start`, `res_valid`, `busy`, `batch_done` = 0; `cnn_din`, `res_label`, `res_classes`, `res_err`, `res_frame`, all counters = 0.
- `go` at cycle t -> `busy` and `cnn_start` at t+1, LOAD from t+2.
- Pixel path zero-latency combinational; core sees the word in the same cycle as its strobe.
- `cnn_done` at cycle d (WAIT) -> `res_valid` at d+1, next `cnn_start` at d+2.
- `res_*` registered, hold value until next REPORT.
- `batch_done` coincides with final `res_valid`; `busy` drops the following cycle.
- `go` coincident with `batch_done` is ignored (state not yet IDLE).

## Test plan
- Single frame, `n_frames`=1, host always valid, core strobes 784 consecutive cycles, `cnn_done` with classes=0x008 -> one `res_valid`, label 3, err 0, frame 0, `batch_done` same cycle.
- Batch `n_frames`=3, classes 0x001/0x200/0x040 -> labels 0, 9, 6, frames 0,1,2; exactly three `cnn_start` pulses; 2352 host words consumed.
- Host drops `s_valid` for pixels 100-104 -> err[0]=1, label still decoded, host consumed 779 words, pixel counter still ends at 784.
- Core never asserts `cnn_done`, TMO=1000 -> `res_valid` 1001 cycles after WAIT entry, err[1]=1, classes 0, label 0xF, err[2]=1.
- classes=0x0C0 -> label 6, err[2]=1; `cnn_done` at pixel 500 -> err[3]=1, no further `s_ready`.
- `abort` at pixel 400 of frame 1 of 3 -> IDLE next cycle, no `res_valid`/`batch_done`; `rst` mid-LOAD -> all outputs at reset values asynchronously; new `go` restarts at frame 0.
